gru_seq_ctrl: RTL and testbench
===============================

Name: gru_seq_ctrl

Overview:
- Upstream sequencer for the combinational gru_lstm cell (8-bit signed X, h_in, h_out).
- Accepts a stream of input samples through a valid/ready handshake and drives X and h_in to the cell. After a fixed settle time it captures h_out, feeds it back as the next h_in, and emits the hidden state downstream.
- Owns the recurrent hidden-state register and the sequence boundaries: first and last sample of each sequence.

Parameters:
- DATA_W, 8: width of X, h_in and h_out. All values are signed two's complement.
- SETTLE_CYCLES, 2: number of cycles cell inputs are held stable before h_out is sampled. Legal range 1..15.
- CNT_W, 8: width of the per-sequence step counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  input sample X.
- in_first  in  1  sample starts a new sequence; h is cleared to 0 before use.
- in_last  in  1  sample ends the current sequence.
- cell_x  out  DATA_W  drives gru_lstm X.
- cell_h  out  DATA_W  drives gru_lstm h_in.
- cell_hout  in  DATA_W  gru_lstm h_out.
- out_valid  out  1  hidden-state output valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  DATA_W  captured hidden state.
- out_last  out  1  output belongs to the last step of a sequence.
- step_cnt  out  CNT_W  index of the current step within the sequence, starting at 0.

Behaviour:
- States: IDLE, SETTLE, CAPTURE, OUT.
- Reset, while rst_n=0 at a clock edge:
  - state=IDLE; in_ready=0 during reset, 1 in the first cycle after reset.
  - out_valid=0, out_data=0, out_last=0, cell_x=0, cell_h=0, h_reg=0, step_cnt=0, settle counter=0.
  - Reset mid-operation aborts the step and discards any pending output.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: cell_x<=in_data; cell_h<=(in_first ? 0 : h_reg); last_q<=in_last; step_cnt<=(in_first ? 0 : step_cnt+1), wrapping modulo 2^CNT_W.
  - Settle counter<=SETTLE_CYCLES-1, then go to SETTLE.
- SETTLE:
  - in_ready=0; cell_x and cell_h are held.
  - Counter decrements each cycle; at 0, go to CAPTURE.
- CAPTURE:
  - h_reg<=cell_hout; out_data<=cell_hout; out_last<=last_q.
  - Go to OUT, with out_valid=1 from the next cycle.
- OUT:
  - out_valid, out_data and out_last are held stable until out_valid&out_ready.
  - On that handshake: out_valid<=0, go to IDLE.
  - in_ready=0 throughout OUT. There is no overlap.
- Latency:
  - in handshake cycle T → out_valid high at T+SETTLE_CYCLES+2.
  - Minimum throughput is one sample per SETTLE_CYCLES+3 cycles with out_ready tied high.
- Sequence boundaries:
  - in_first and in_last may both be 1 (length-1 sequence).
  - After an in_last sample, the next sample without in_first continues from h_reg. No implicit clear.
- in_valid dropped while in_ready=0 is ignored; no sample is lost or duplicated.
- out_ready toggling while out_valid=0 has no effect.
- Arithmetic: the block does none. h is passed through bit-exact; no saturation or rescaling.

Optional Feature:
- Macro: GRU_SEQ_LAST_ONLY_EN.
- Defined (sequence-to-one mode):
  - CAPTURE goes straight to IDLE without asserting out_valid unless last_q=1.
  - h_reg is still updated every step.
  - out_last is always 1 when out_valid=1.
- Undefined: an output is produced every step, as described above.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 → out_valid=0, cell_h=0, step_cnt=0; in_ready=1 in the first cycle after release.
- Basic step:
  - Bench model cell_hout=cell_x+cell_h (8-bit wrap); SETTLE_CYCLES=2; out_ready=1.
  - Input X=8'h80 with first=1 → cell_h=0; out_data=8'h80 at handshake+4; out_last=0.
- Recurrence:
  - Sequence X=8'h10 (first), 8'h01, 8'hF0 (last).
  - Outputs 8'h10, 8'h11, 8'h01 with step_cnt 0, 1, 2; out_last only on the third output.
- Backpressure: out_ready=0 for 10 cycles after out_valid → out_data held, in_ready=0, a second in_valid is not accepted; the output completes once out_ready=1.
- New sequence clears state: after h_reg=8'h11, send X=8'h05 with first=1 → cell_h=0, out_data=8'h05, step_cnt=0.
- Mid-op reset: assert rst_n=0 during SETTLE → next cycle out_valid=0 and h_reg=0; the following sample without first uses cell_h=0.
- With GRU_SEQ_LAST_ONLY_EN: the three-sample sequence above yields exactly one output, 8'h01, with out_last=1.

Source files
------------

// File: rtl/gru_seq_ctrl.sv
// gru_seq_ctrl
//   Upstream sequencer for the combinational gru_lstm cell. It takes input
//   samples over a valid/ready handshake, drives X and h_in to the cell, waits
//   SETTLE_CYCLES for the cell to settle, captures h_out into the recurrent
//   hidden-state register and emits it downstream. It also tracks the sequence
//   boundaries (first/last) and the step index inside the current sequence.
//
//   Handshakes: a transfer happens on a rising clock edge where both valid and
//   ready are 1. The producer holds data stable while valid=1 and ready=0. The
//   ready signal of either port never depends on the valid signal of that port.
//
//   Optional build macro GRU_SEQ_LAST_ONLY_EN (sequence-to-one mode): only the
//   last step of a sequence produces an output; h is still updated every step.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   input sample valid
//   in_ready   out  block can accept a sample
//   in_data    in   input sample X (signed)
//   in_first   in   sample starts a new sequence (h cleared before use)
//   in_last    in   sample ends the current sequence
//   cell_x     out  drives gru_lstm X
//   cell_h     out  drives gru_lstm h_in
//   cell_hout  in   gru_lstm h_out
//   out_valid  out  hidden-state output valid
//   out_ready  in   downstream accepts output
//   out_data   out  captured hidden state
//   out_last   out  output belongs to the last step of a sequence
//   step_cnt   out  step index inside the sequence, starting at 0
//   dbg_state  out  current FSM state (0 IDLE, 1 SETTLE, 2 CAPTURE, 3 OUT)
module gru_seq_ctrl #(
    parameter int DATA_W        = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_first,
    input  logic              in_last,
    output logic [DATA_W-1:0] cell_x,
    output logic [DATA_W-1:0] cell_h,
    input  logic [DATA_W-1:0] cell_hout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [CNT_W-1:0]  step_cnt,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_OUT     = 2'd3
    } state_t;

    // The counter is loaded with SETTLE_CYCLES-1 so that the cell inputs stay
    // stable for exactly SETTLE_CYCLES cycles in SETTLE before CAPTURE.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_settle_cnt;
    logic [DATA_W-1:0]   r_cell_x;
    logic [DATA_W-1:0]   r_cell_h;
    logic [DATA_W-1:0]   r_h;
    logic                r_last_q;
    logic [CNT_W-1:0]    r_step;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_last;
    logic                w_accept;
    logic                w_in_ready;
    logic                w_out_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs. in_ready is gated by rst_n so that it
    // reads 0 for the whole reset window and 1 as soon as reset is released.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = rst_n;
                if (in_valid && rst_n) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_settle_cnt == 4'd0) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
`ifdef GRU_SEQ_LAST_ONLY_EN
                w_state_nxt = r_last_q ? S_OUT : S_IDLE;
`else
                w_state_nxt = S_OUT;
`endif
            end
            S_OUT: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_accept = in_valid & w_in_ready;

    // Datapath: cell drive, recurrent state, step counter and output holding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_settle_cnt <= 4'd0;
            r_cell_x     <= '0;
            r_cell_h     <= '0;
            r_h          <= '0;
            r_last_q     <= 1'b0;
            r_step       <= '0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cell_x     <= in_data;
                        r_cell_h     <= in_first ? '0 : r_h;
                        r_last_q     <= in_last;
                        r_step       <= in_first ? '0 : r_step + CNT_W'(1);
                        r_settle_cnt <= SETTLE_LOAD;
                    end
                end
                S_SETTLE: begin
                    if (r_settle_cnt != 4'd0) begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    // h is passed through bit-exact, no saturation.
                    r_h        <= cell_hout;
                    r_out_data <= cell_hout;
                    r_out_last <= r_last_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign cell_x    = r_cell_x;
    assign cell_h    = r_cell_h;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign step_cnt  = r_step;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_gru_seq_ctrl.sv
module tb_gru_seq_ctrl;

    localparam int DW = 8;
    localparam int S  = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_first;
    logic          in_last;
    logic [DW-1:0] cell_x;
    logic [DW-1:0] cell_h;
    logic [DW-1:0] cell_hout;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [CW-1:0] step_cnt;
    logic [1:0]    dbg_state;

    gru_seq_ctrl #(.DATA_W(DW), .SETTLE_CYCLES(S), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_first  (in_first),
        .in_last   (in_last),
        .cell_x    (cell_x),
        .cell_h    (cell_h),
        .cell_hout (cell_hout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .step_cnt  (step_cnt),
        .dbg_state (dbg_state)
    );

    // Stand-in for the gru_lstm cell: h_out = X + h_in, 8-bit wrap.
    assign cell_hout = cell_x + cell_h;

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d t=%0t", name, act, exp, cyc, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic [CW-1:0] s;
        int            due;
    } exp_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic [CW-1:0] s;
    } got_t;

    exp_t          exp_q[$];
    got_t          got_q[$];
    logic [DW-1:0] m_h    = '0;
    logic [CW-1:0] m_step = '0;
    logic [DW-1:0] m_cx   = '0;
    logic [DW-1:0] m_ch   = '0;
    int            m_idle_at = 0;
    int            acc_cnt = 0;
    int            acc_cyc = 0;
    int            prev_acc_cyc = 0;
    int            rise_cyc = 0;
    logic          ov_prev = 1'b0;
    bit            chk_en = 1'b0;

    function automatic bit model_out_valid();
        return (exp_q.size() > 0) && (cyc >= exp_q[0].due);
    endfunction

    // One compare process: checks the cycle's outputs, then advances the model
    // to the next cycle from the inputs the bench is driving.
    always @(negedge clk) begin
        if (chk_en) begin
            bit   e_ov;
            bit   e_ir;
            bit   emit;
            logic e_last;
            exp_t e;
            e_ov = model_out_valid();
            e_ir = rst_n && (exp_q.size() == 0) && (cyc >= m_idle_at);
            chk("in_ready", in_ready, e_ir);
            chk("out_valid", out_valid, e_ov);
            chk("cell_x", cell_x, m_cx);
            chk("cell_h", cell_h, m_ch);
            chk("step_cnt", step_cnt, m_step);
            if (e_ov) begin
                chk("out_data", out_data, exp_q[0].d);
                chk("out_last", out_last, exp_q[0].l);
            end
            // observed-output records for the literal checks
            if (out_valid && !ov_prev) rise_cyc = cyc;
            ov_prev = out_valid;
            if (out_valid && out_ready) got_q.push_back('{d: out_data, l: out_last, s: step_cnt});
            // advance model
            if (!rst_n) begin
                exp_q.delete();
                m_h = '0; m_step = '0; m_cx = '0; m_ch = '0;
                m_idle_at = 0;
            end else begin
                if (e_ov && out_ready) begin
                    void'(exp_q.pop_front());
                    m_idle_at = cyc + 1;
                end
                if (in_valid && e_ir) begin
                    m_ch   = in_first ? '0 : m_h;
                    m_cx   = in_data;
                    m_step = in_first ? '0 : m_step + 1'b1;
                    m_h    = m_cx + m_ch;
                    m_idle_at = cyc + S + 2;
`ifdef GRU_SEQ_LAST_ONLY_EN
                    emit   = in_last;
                    e_last = 1'b1;
`else
                    emit   = 1'b1;
                    e_last = in_last;
`endif
                    if (emit) begin
                        e.d = m_h; e.l = e_last; e.s = m_step; e.due = cyc + S + 2;
                        exp_q.push_back(e);
                    end
                    acc_cnt++;
                    prev_acc_cyc = acc_cyc;
                    acc_cyc = cyc;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [DW-1:0] x, input logic first, input logic last, input bit keep);
        int n0;
        n0 = acc_cnt;
        in_data  = x;
        in_first = first;
        in_last  = last;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (acc_cnt != n0) break;
        end
        chk("accept_timeout", (acc_cnt != n0), 1);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && cyc >= m_idle_at) break;
            @(posedge clk); #1;
        end
        chk("drain_timeout", (i < 200), 1);
    endtask

    task automatic got(input string name, input logic [DW-1:0] d, input logic l, input logic [CW-1:0] s);
        got_t g;
        if (got_q.size() == 0) begin
            chk({name, "_missing"}, got_q.size(), 1);
        end else begin
            g = got_q.pop_front();
            chk({name, "_data"}, g.d, d);
            chk({name, "_last"}, g.l, l);
            chk({name, "_step"}, g.s, s);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        in_first  = 1'b1;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // reset held 3 cycles with in_valid asserted
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_cell_h", cell_h, 0);
        chk("rst_step", step_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // basic step
        send(8'h80, 1'b1, 1'b0, 1'b0);
        drain();
`ifdef GRU_SEQ_LAST_ONLY_EN
        chk("basic_none", got_q.size(), 0);
`else
        got("basic", 8'h80, 1'b0, 8'd0);
`endif

        // recurrence
        send(8'h10, 1'b1, 1'b0, 1'b0);
        send(8'h01, 1'b0, 1'b0, 1'b0);
        send(8'hF0, 1'b0, 1'b1, 1'b0);
        drain();
`ifndef GRU_SEQ_LAST_ONLY_EN
        got("rec0", 8'h10, 1'b0, 8'd0);
        got("rec1", 8'h11, 1'b0, 8'd1);
`endif
        got("rec2", 8'h01, 1'b1, 8'd2);
        chk("rec_count", got_q.size(), 0);

        // continuation after last without first: no implicit clear
        send(8'h02, 1'b0, 1'b1, 1'b0);
        drain();
        got("cont", 8'h03, 1'b1, 8'd3);

        // new sequence clears h, with out_ready toggling in the background
        fork
            begin
                send(8'h10, 1'b1, 1'b0, 1'b0);
                send(8'h01, 1'b0, 1'b0, 1'b0);
                send(8'h05, 1'b1, 1'b1, 1'b0);
            end
            begin
                repeat (40) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();
`ifndef GRU_SEQ_LAST_ONLY_EN
        got("clr0", 8'h10, 1'b0, 8'd0);
        got("clr1", 8'h11, 1'b0, 8'd1);
`endif
        got("clr2", 8'h05, 1'b1, 8'd0);

        // backpressure: output held 10 cycles, second sample must wait
        out_ready = 1'b0;
        send(8'h20, 1'b1, 1'b1, 1'b0);
        fork
            send(8'h30, 1'b0, 1'b1, 1'b0);
            begin
                int i;
                for (i = 0; i < 50; i++) begin
                    if (model_out_valid()) break;
                    @(posedge clk); #1;
                end
                chk("bp_valid_timeout", (i < 50), 1);
                repeat (10) @(posedge clk);
                #1;
                chk("bp_held_in_ready", in_ready, 0);
                chk("bp_held_out_data", out_data, 8'h20);
                out_ready = 1'b1;
            end
        join
        drain();
        got("bp0", 8'h20, 1'b1, 8'd0);
        got("bp1", 8'h50, 1'b1, 8'd1);

        // reset during SETTLE aborts the step and clears h
        send(8'h7F, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_cell_h", cell_h, 0);
        chk("midrst_step", step_cnt, 0);
        rst_n = 1'b1;
        send(8'h03, 1'b0, 1'b1, 1'b0);
        drain();
        got("midrst", 8'h03, 1'b1, 8'd1);
        chk("midrst_count", got_q.size(), 0);
        chk("latency", rise_cyc - acc_cyc, S + 2);

        // back-to-back samples with in_valid held high
        send(8'h01, 1'b1, 1'b0, 1'b1);
        send(8'h02, 1'b0, 1'b0, 1'b1);
        send(8'h03, 1'b0, 1'b1, 1'b0);
`ifdef GRU_SEQ_LAST_ONLY_EN
        chk("throughput", acc_cyc - prev_acc_cyc, S + 2);
`else
        chk("throughput", acc_cyc - prev_acc_cyc, S + 3);
`endif
        drain();
`ifndef GRU_SEQ_LAST_ONLY_EN
        got("tp0", 8'h01, 1'b0, 8'd0);
        got("tp1", 8'h03, 1'b0, 8'd1);
`endif
        got("tp2", 8'h06, 1'b1, 8'd2);

        // step counter wraps modulo 256
        got_q.delete();
        send(8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            send(8'h01, 1'b0, (i == 255), 1'b0);
        end
        drain();
`ifdef GRU_SEQ_LAST_ONLY_EN
        chk("wrap_count", got_q.size(), 1);
`else
        chk("wrap_count", got_q.size(), 257);
`endif
        if (got_q.size() > 0) begin
            chk("wrap_data", got_q[$].d, 8'h00);
            chk("wrap_step", got_q[$].s, 8'h00);
            chk("wrap_last", got_q[$].l, 1);
        end else begin
            chk("wrap_missing", got_q.size(), 1);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
